ac97_link_receiver: RTL and testbench
=====================================

# ac97_link_receiver

- Receive (SDI) half of the AC-link, on the controller side.
- Deserialises the LM4550's serial output frames and tracks frame alignment from the controller-driven SYNC.
- Decodes the slot-0 tag, slot-1/2 status (register read-back) and slot-3/4 PCM capture samples.
- Sits beside the AC-link transmit path inside the top-level audio module and feeds register-read and record logic.

## Interface

Parameters:
- SyncLockFrames, 2: consecutive correctly spaced SYNC rises required before Locked asserts.

Ports:
- AC97BitClock  input  1  Single clock for the block; 12.288 MHz bit clock from the codec.
- Rstn  input  1  Reset. Synchronous, active-low. The parent holds it low for at least 4 AC97BitClock edges after the codec clock starts.
- AC97SDI  input  1  Serial data from the codec, sampled on the rising edge.
- AC97Sync  input  1  Frame sync, as driven onto the link by the controller.
- Locked  output  1  Frame alignment established.
- FrameError  output  1  One-cycle pulse on a misplaced or missing SYNC.
- CodecReady  output  1  Slot-0 bit 15 of the last complete frame.
- SlotTag  output  12  Slot-0 tag bits 14:3, i.e. slot 1..12 valid flags. Bit 0 corresponds to slot 1.
- StatusAddr  output  7  Slot-1 bits 18:12.
- StatusData  output  16  Slot-2 bits 19:4.
- StatusValid  output  1  One-cycle pulse.
- PcmLeft  output  20  Slot-3 sample, MSB first, two's complement.
- PcmRight  output  20  Slot-4 sample.
- PcmValid  output  1  One-cycle pulse.

## Operation

- **Reset values.** All outputs are 0 while Rstn is low, the bit counter is 0 and the tracker is in HUNT.
- **SYNC rise.** Detected as registered previous AC97Sync = 0 and current AC97Sync = 1. The edge where the rise is seen samples the last bit (255) of the previous frame. The next edge samples frame bit 0 (tag bit 15).
- **Frame layout.** Frame bits 0..255 are MSB-first:
  - Slot 0: bits 0-15.
  - Slot n (1..12): bits 16+20(n-1) through 35+20(n-1).
  - Slot 1 ends at bit 35, slot 2 at 55, slot 3 at 75, slot 4 at 95.
- **Tracker states:**
  - HUNT -> ALIGN on any SYNC rise. The counter loads 0 for the next edge.
  - ALIGN: the counter runs 0..255. A SYNC rise at count 255 increments the good-frame count. On reaching SyncLockFrames the tracker goes to LOCKED and Locked becomes 1.
  - LOCKED: the counter wraps 255 -> 0.
  - In ALIGN or LOCKED, a SYNC rise at any count other than 255 pulses FrameError, sets Locked to 0, enters ALIGN and restarts the counter at 0 for the next edge.
  - In LOCKED, count 255 with no SYNC rise pulses FrameError and returns the tracker to HUNT with Locked = 0.
- **Decoding.** A 20-bit shift register captures SDI on every edge. Decoded outputs update only in LOCKED; in other states they hold their last values.
- **Slot 0 (end of bit 15).**
  - CodecReady is loaded from tag bit 15.
  - SlotTag is loaded from tag bits 14:3.
  - Tag bits 2:0 are ignored.
- **Status path.**
  - StatusAddr is latched at the end of slot 1 if SlotTag[0] = 1.
  - StatusData is latched at the end of slot 2 if SlotTag[1] = 1.
  - StatusValid pulses if both SlotTag[0] and SlotTag[1] are set.
- **PCM path.**
  - PcmLeft is latched at the end of slot 3 if SlotTag[2] = 1.
  - PcmRight is latched at the end of slot 4 if SlotTag[3] = 1.
  - PcmValid pulses at the end of slot 4 if SlotTag[2] or SlotTag[3] is set. An unflagged channel holds its previous value.
- **Ignored slots.** Slots 5-12 are shifted through and discarded.
- **Reset mid-frame.** All state clears immediately. No pulse is emitted for the partial frame.

## Timing

- All outputs are registered.
- A value latched from a slot whose last bit is sampled on edge k is visible after edge k+1:
  - CodecReady and SlotTag: frame bit 15 + 1.
  - StatusValid: frame bit 55 + 1.
  - PcmValid: frame bit 95 + 1.
- StatusValid, PcmValid and FrameError are high for exactly one AC97BitClock cycle. There is at most one StatusValid and one PcmValid per 256-cycle frame.
- Locked rises one cycle after the SYNC-rise edge that completes the SyncLockFrames-th good frame.
- If FrameError and PcmValid would coincide, FrameError wins and PcmValid is suppressed.

## Structure

- **Package ac97_pkg** holds:
  - Constants: FrameBits = 256, Slot0Bits = 16, SlotBits = 20, and the end-of-slot indices for slots 0..4 (15, 35, 55, 75, 95).
  - The tracker-state enum {HUNT, ALIGN, LOCKED}.
- **Sub-module ac97_frame_tracker** contains SYNC edge detection, the 8-bit bit counter, the good-frame counter, the state machine and FrameError. It exports the bit index and an in-lock strobe.
- **Top level** holds the shift register and slot decode.

## Test plan

- **Lock-up.** Reset, then 3 frames with SYNC high for 16 bits every 256 cycles -> Locked = 1 after the 2nd good SYNC rise, FrameError never pulses.
- **Status read-back.** Tag 0xE000 (ready, slot 1, slot 2 valid), slot 1 = 0x7C000 (address 0x7C), slot 2 = 0x45900 -> CodecReady = 1, StatusAddr = 0x7C, StatusData = 0x4590, StatusValid one cycle after bit 55.
- **PCM capture.** Tag 0x9800, slot 3 = 0x80001, slot 4 = 0x7FFFF -> PcmLeft = 0x80001, PcmRight = 0x7FFFF, PcmValid one cycle after bit 95. A following frame with tag 0x9000 -> PcmLeft updates, PcmRight holds 0x7FFFF.
- **Early SYNC.** While locked, SYNC rises at count 100 -> FrameError pulse, Locked = 0, no PcmValid or StatusValid in that frame. Locked returns after 2 further good frames.
- **Missing SYNC.** While locked, SYNC held low across count 255 -> FrameError pulse, state HUNT, outputs hold. The next SYNC rise enters ALIGN.
- **Reset mid-frame.** Rstn low at bit 60 for 4 cycles -> all outputs 0, no pulses. Re-lock after 2 good frames.

Source files
------------

// File: rtl/ac97_pkg.sv
// Shared constants and types for the AC-link SDI receiver: frame geometry,
// slot boundaries and the frame-tracker state encoding.
package ac97_pkg;

    localparam int FrameBits = 256;
    localparam int Slot0Bits = 16;
    localparam int SlotBits  = 20;

    localparam int Slot0End = Slot0Bits - 1;
    localparam int Slot1End = Slot0End + SlotBits;
    localparam int Slot2End = Slot1End + SlotBits;
    localparam int Slot3End = Slot2End + SlotBits;
    localparam int Slot4End = Slot3End + SlotBits;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } tracker_state_t;

    // Tag bits 14:3 arrive slot-1 first; flip them so index 0 is slot 1.
    function automatic logic [11:0] tag_to_slot_flags(input logic [11:0] i_tag_bits);
        logic [11:0] w_flags;
        for (int i = 0; i < 12; i++) begin
            w_flags[i] = i_tag_bits[11 - i];
        end
        return w_flags;
    endfunction

endpackage

// File: rtl/ac97_frame_tracker.sv
// SYNC edge detection, bit counter and frame-alignment state machine for the
// AC-link receive path; exports the current bit index and an in-lock strobe.
module ac97_frame_tracker
    import ac97_pkg::*;
#(
    parameter int SyncLockFrames = 2
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_sync,
    output logic [7:0] o_bit_idx,
    output logic       o_in_lock,
    output logic       o_locked,
    output logic       o_frame_err
);

    tracker_state_t r_state;
    tracker_state_t w_state_nxt;
    logic           r_sync_prev;
    logic [7:0]     r_cnt;
    logic [7:0]     w_cnt_nxt;
    logic [7:0]     r_good;
    logic [7:0]     w_good_nxt;
    logic           r_frame_err;
    logic           w_err_nxt;
    logic           w_rise;
    logic           w_at_end;
    logic           w_lock_reached;

    assign w_rise         = i_sync & ~r_sync_prev;
    assign w_at_end       = (r_cnt == 8'(FrameBits - 1));
    assign w_lock_reached = (int'(r_good) + 1) >= SyncLockFrames;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= HUNT;
            r_sync_prev <= 1'b0;
            r_cnt       <= '0;
            r_good      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sync_prev <= i_sync;
            r_cnt       <= w_cnt_nxt;
            r_good      <= w_good_nxt;
            r_frame_err <= w_err_nxt;
        end
    end

    // r_cnt is the index of the frame bit sampled on the current edge, so a
    // correctly placed SYNC rise always lands while r_cnt is 255.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 8'd1;
        w_good_nxt  = r_good;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            HUNT: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = ALIGN;
                    w_good_nxt  = '0;
                end
            end
            ALIGN: begin
                if (w_rise) begin
                    w_cnt_nxt = '0;
                    if (w_at_end) begin
                        if (w_lock_reached) begin
                            w_state_nxt = LOCKED;
                            w_good_nxt  = '0;
                        end else begin
                            w_good_nxt = r_good + 8'd1;
                        end
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_good_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (w_rise) begin
                    w_cnt_nxt = '0;
                    if (!w_at_end) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ALIGN;
                        w_good_nxt  = '0;
                    end
                end else if (w_at_end) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = HUNT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_cnt_nxt   = '0;
                w_good_nxt  = '0;
            end
        endcase
    end

    // Decode is blocked on the edge that flags an error so a misplaced SYNC
    // can never coincide with a valid pulse.
    always_comb begin
        o_bit_idx   = r_cnt;
        o_locked    = (r_state == LOCKED);
        o_in_lock   = (r_state == LOCKED) && !w_err_nxt;
        o_frame_err = r_frame_err;
    end

endmodule

// File: rtl/ac97_link_receiver.sv
// Controller-side AC-link SDI receiver: deserialises codec frames and decodes
// the slot-0 tag, slot-1/2 status read-back and slot-3/4 PCM capture.
module ac97_link_receiver
    import ac97_pkg::*;
#(
    parameter int SyncLockFrames = 2
) (
    input  logic        AC97BitClock,
    input  logic        Rstn,
    input  logic        AC97SDI,
    input  logic        AC97Sync,
    output logic        Locked,
    output logic        FrameError,
    output logic        CodecReady,
    output logic [11:0] SlotTag,
    output logic [6:0]  StatusAddr,
    output logic [15:0] StatusData,
    output logic        StatusValid,
    output logic [19:0] PcmLeft,
    output logic [19:0] PcmRight,
    output logic        PcmValid
);

    // Each slot is decoded one edge after its last bit, once the shift
    // register holds the whole slot.
    localparam logic [7:0] DecTag   = 8'(Slot0End + 1);
    localparam logic [7:0] DecAddr  = 8'(Slot1End + 1);
    localparam logic [7:0] DecData  = 8'(Slot2End + 1);
    localparam logic [7:0] DecLeft  = 8'(Slot3End + 1);
    localparam logic [7:0] DecRight = 8'(Slot4End + 1);

    logic [7:0]  w_bit_idx;
    logic        w_in_lock;
    logic        w_locked;
    logic        w_frame_err;

    logic [19:0] r_shift;
    logic        r_codec_ready;
    logic [11:0] r_slot_tag;
    logic [6:0]  r_status_addr;
    logic [15:0] r_status_data;
    logic        r_status_valid;
    logic [19:0] r_pcm_left;
    logic [19:0] r_pcm_right;
    logic        r_pcm_valid;

    ac97_frame_tracker #(
        .SyncLockFrames (SyncLockFrames)
    ) u_tracker (
        .i_clk       (AC97BitClock),
        .i_rstn      (Rstn),
        .i_sync      (AC97Sync),
        .o_bit_idx   (w_bit_idx),
        .o_in_lock   (w_in_lock),
        .o_locked    (w_locked),
        .o_frame_err (w_frame_err)
    );

    always_ff @(posedge AC97BitClock) begin
        if (!Rstn) begin
            r_shift        <= '0;
            r_codec_ready  <= 1'b0;
            r_slot_tag     <= '0;
            r_status_addr  <= '0;
            r_status_data  <= '0;
            r_status_valid <= 1'b0;
            r_pcm_left     <= '0;
            r_pcm_right    <= '0;
            r_pcm_valid    <= 1'b0;
        end else begin
            r_shift        <= {r_shift[18:0], AC97SDI};
            r_status_valid <= 1'b0;
            r_pcm_valid    <= 1'b0;
            if (w_in_lock) begin
                unique case (w_bit_idx)
                    DecTag: begin
                        r_codec_ready <= r_shift[15];
                        r_slot_tag    <= tag_to_slot_flags(r_shift[14:3]);
                    end
                    DecAddr: begin
                        if (r_slot_tag[0]) begin
                            r_status_addr <= r_shift[18:12];
                        end
                    end
                    DecData: begin
                        if (r_slot_tag[1]) begin
                            r_status_data <= r_shift[19:4];
                        end
                        r_status_valid <= r_slot_tag[0] & r_slot_tag[1];
                    end
                    DecLeft: begin
                        if (r_slot_tag[2]) begin
                            r_pcm_left <= r_shift;
                        end
                    end
                    DecRight: begin
                        if (r_slot_tag[3]) begin
                            r_pcm_right <= r_shift;
                        end
                        r_pcm_valid <= r_slot_tag[2] | r_slot_tag[3];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign Locked      = w_locked;
    assign FrameError  = w_frame_err;
    assign CodecReady  = r_codec_ready;
    assign SlotTag     = r_slot_tag;
    assign StatusAddr  = r_status_addr;
    assign StatusData  = r_status_data;
    assign StatusValid = r_status_valid;
    assign PcmLeft     = r_pcm_left;
    assign PcmRight    = r_pcm_right;
    assign PcmValid    = r_pcm_valid;

endmodule

// File: tb/tb_ac97_link_receiver.sv
// Self-checking bench for ac97_link_receiver: randomized frames compared each
// cycle against a frame-level reference model, plus directed scenario checks.
module tb_ac97_link_receiver;

    localparam int LockN = 2;

    logic        AC97BitClock = 1'b0;
    logic        Rstn         = 1'b0;
    logic        AC97SDI      = 1'b0;
    logic        AC97Sync     = 1'b0;
    logic        Locked;
    logic        FrameError;
    logic        CodecReady;
    logic [11:0] SlotTag;
    logic [6:0]  StatusAddr;
    logic [15:0] StatusData;
    logic        StatusValid;
    logic [19:0] PcmLeft;
    logic [19:0] PcmRight;
    logic        PcmValid;

    ac97_link_receiver #(.SyncLockFrames(LockN)) dut (
        .AC97BitClock (AC97BitClock),
        .Rstn         (Rstn),
        .AC97SDI      (AC97SDI),
        .AC97Sync     (AC97Sync),
        .Locked       (Locked),
        .FrameError   (FrameError),
        .CodecReady   (CodecReady),
        .SlotTag      (SlotTag),
        .StatusAddr   (StatusAddr),
        .StatusData   (StatusData),
        .StatusValid  (StatusValid),
        .PcmLeft      (PcmLeft),
        .PcmRight     (PcmRight),
        .PcmValid     (PcmValid)
    );

    always #5 AC97BitClock = ~AC97BitClock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: frame position, alignment mode and received bits by index
    int          m_mode;      // 0 hunting, 1 aligning, 2 locked
    int          m_pos;
    int          m_good;
    logic        m_prev;
    logic        m_bits [256];
    logic        e_locked, e_err, e_ready, e_sv, e_pv;
    logic [11:0] e_tag;
    logic [6:0]  e_addr;
    logic [15:0] e_data;
    logic [19:0] e_left, e_right;

    function automatic logic [19:0] fetch(input int first, input int n);
        logic [19:0] v = '0;
        for (int k = 0; k < n; k++) v = {v[18:0], m_bits[first + k]};
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_prev = 1'b0;
        e_locked = 0; e_err = 0; e_ready = 0; e_sv = 0; e_pv = 0;
        e_tag = '0; e_addr = '0; e_data = '0; e_left = '0; e_right = '0;
    endtask

    task automatic model_edge(input logic sdi, input logic sync, input logic rstn);
        logic        rise;
        logic        was_locked;
        int          pos;
        logic [19:0] w;
        if (!rstn) begin
            model_reset();
            return;
        end
        rise   = !m_prev && sync;
        m_prev = sync;
        pos    = m_pos;
        m_bits[pos] = sdi;
        e_sv = 0; e_pv = 0; e_err = 0;
        was_locked = (m_mode == 2);
        if (m_mode == 0) begin
            if (rise) begin m_mode = 1; m_good = 0; end
            m_pos = 0;
        end else if (rise && pos != 255) begin
            e_err = 1; m_mode = 1; m_good = 0; m_pos = 0;
        end else if (rise) begin
            if (m_mode == 1) begin
                m_good++;
                if (m_good >= LockN) m_mode = 2;
            end
            m_pos = 0;
        end else if (m_mode == 2 && pos == 255) begin
            e_err = 1; m_mode = 0; m_pos = 0;
        end else begin
            m_pos = (pos + 1) % 256;
        end
        if (was_locked && !e_err) begin
            if (pos == 16) begin
                w = fetch(0, 16);
                e_ready = w[15];
                for (int b = 0; b < 12; b++) e_tag[b] = w[14 - b];
            end else if (pos == 36) begin
                w = fetch(16, 20);
                if (e_tag[0]) e_addr = w[18:12];
            end else if (pos == 56) begin
                w = fetch(36, 20);
                if (e_tag[1]) e_data = w[19:4];
                e_sv = e_tag[0] && e_tag[1];
            end else if (pos == 76) begin
                w = fetch(56, 20);
                if (e_tag[2]) e_left = w;
            end else if (pos == 96) begin
                w = fetch(76, 20);
                if (e_tag[3]) e_right = w;
                e_pv = e_tag[2] || e_tag[3];
            end
        end
        e_locked = (m_mode == 2);
    endtask

    function automatic logic [79:0] dut_vec();
        return {Locked, FrameError, CodecReady, SlotTag, StatusAddr, StatusData,
                StatusValid, PcmLeft, PcmRight, PcmValid};
    endfunction

    function automatic logic [79:0] model_vec();
        return {e_locked, e_err, e_ready, e_tag, e_addr, e_data, e_sv, e_left, e_right, e_pv};
    endfunction

    task automatic drive_cycle(input logic sdi, input logic sync, input logic rstn);
        @(negedge AC97BitClock);
        AC97SDI  = sdi;
        AC97Sync = sync;
        Rstn     = rstn;
        @(posedge AC97BitClock);
        model_edge(sdi, sync, rstn);
        #1;
        check("cycle", dut_vec(), model_vec());
    endtask

    // Stimulus frame and per-run observations
    logic fb [256];
    int   sync_left = 0;
    int   sv_n, pv_n, err_n, sv_at, pv_at, err_at;

    task automatic set_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                             input logic [19:0] s3, input logic [19:0] s4);
        logic [19:0] v;
        for (int i = 0; i < 16; i++) fb[i] = tag[15 - i];
        for (int n = 1; n <= 12; n++) begin
            case (n)
                1:       v = s1;
                2:       v = s2;
                3:       v = s3;
                4:       v = s4;
                default: v = 20'($urandom);
            endcase
            for (int k = 0; k < 20; k++) fb[16 + 20 * (n - 1) + k] = v[19 - k];
        end
    endtask

    task automatic set_random_frame();
        set_frame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
    endtask

    task automatic run_frame(input int len, input int raise_at, input int rst_at);
        logic s, r;
        sv_n = 0; pv_n = 0; err_n = 0; sv_at = -1; pv_at = -1; err_at = -1;
        for (int i = 0; i < len; i++) begin
            if (i == raise_at) sync_left = 16;
            s = (sync_left > 0);
            if (sync_left > 0) sync_left--;
            r = !(rst_at >= 0 && i >= rst_at && i < rst_at + 4);
            drive_cycle(fb[i], s, r);
            if (StatusValid) begin sv_n++; sv_at = i; end
            if (PcmValid)    begin pv_n++; pv_at = i; end
            if (FrameError)  begin err_n++; err_at = i; end
            if (rst_at >= 0 && i == rst_at + 3) check("rst_mid_zero", dut_vec(), 80'd0);
        end
    endtask

    initial begin
        int          err_total;
        logic [19:0] r3;
        model_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b0);
        check("reset_state", dut_vec(), 80'd0);

        // Lock-up from reset
        err_total = 0;
        for (int f = 0; f < 3; f++) begin
            set_random_frame();
            run_frame(256, 255, -1);
            err_total += err_n;
        end
        check("lock_locked", 80'(Locked), 80'd1);
        check("lock_no_err", 80'(err_total), 80'd0);

        // Status read-back
        set_frame(16'hE000, 20'h7C000, 20'h45900, 20'($urandom), 20'($urandom));
        run_frame(256, 255, -1);
        check("stat_valid_n", 80'(sv_n), 80'd1);
        check("stat_valid_at", 80'(sv_at), 80'd56);
        check("stat_ready", 80'(CodecReady), 80'd1);
        check("stat_addr", 80'(StatusAddr), 80'h7C);
        check("stat_data", 80'(StatusData), 80'h4590);

        // PCM capture, then left-only update
        set_frame(16'h9800, 20'($urandom), 20'($urandom), 20'h80001, 20'h7FFFF);
        run_frame(256, 255, -1);
        check("pcm_valid_n", 80'(pv_n), 80'd1);
        check("pcm_valid_at", 80'(pv_at), 80'd96);
        check("pcm_left", 80'(PcmLeft), 80'h80001);
        check("pcm_right", 80'(PcmRight), 80'h7FFFF);
        r3 = 20'($urandom);
        set_frame(16'h9000, 20'($urandom), 20'($urandom), r3, 20'($urandom));
        run_frame(256, 255, -1);
        check("pcm_left_upd", 80'(PcmLeft), 80'(r3));
        check("pcm_right_hold", 80'(PcmRight), 80'h7FFFF);

        for (int f = 0; f < 8; f++) begin
            set_random_frame();
            run_frame(256, 255, -1);
        end

        // Early SYNC at count 100
        set_random_frame();
        run_frame(101, 100, -1);
        check("early_err_n", 80'(err_n), 80'd1);
        check("early_unlocked", 80'(Locked), 80'd0);
        set_frame(16'hFFF8, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
        run_frame(256, 255, -1);
        check("early_no_pulse", 80'(sv_n + pv_n), 80'd0);
        check("early_still_align", 80'(Locked), 80'd0);
        set_random_frame();
        run_frame(256, 255, -1);
        check("early_relock", 80'(Locked), 80'd1);

        // Early SYNC exactly on the PCM decode edge
        set_random_frame();
        run_frame(256, 255, -1);
        set_frame(16'h9800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
        run_frame(97, 96, -1);
        check("coinc_err_at", 80'(err_at), 80'd96);
        check("coinc_no_pcm", 80'(pv_n), 80'd0);
        for (int f = 0; f < 2; f++) begin
            set_random_frame();
            run_frame(256, 255, -1);
        end
        check("coinc_relock", 80'(Locked), 80'd1);

        // Missing SYNC
        set_random_frame();
        run_frame(256, -1, -1);
        check("miss_err_n", 80'(err_n), 80'd1);
        check("miss_err_at", 80'(err_at), 80'd255);
        check("miss_unlocked", 80'(Locked), 80'd0);
        set_random_frame();
        run_frame(256, 255, -1);
        check("miss_hunt_no_err", 80'(err_n), 80'd0);
        for (int f = 0; f < 2; f++) begin
            set_random_frame();
            run_frame(256, 255, -1);
        end
        check("miss_relock", 80'(Locked), 80'd1);

        // Reset mid-frame
        set_random_frame();
        run_frame(256, 255, 60);
        check("rst_unlocked", 80'(Locked), 80'd0);
        set_random_frame();
        run_frame(256, 255, -1);
        check("rst_align", 80'(Locked), 80'd0);
        set_random_frame();
        run_frame(256, 255, -1);
        check("rst_relock", 80'(Locked), 80'd1);

        for (int f = 0; f < 3; f++) begin
            set_random_frame();
            run_frame(256, 255, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
